// File: rtl/sum_seq_ctrl.sv
// sum_seq_ctrl: sequences one addition through a shared external adder and
// scans the captured {CO,S} onto a two-digit multiplexed 7-segment display.
module sum_seq_ctrl #(
    parameter int SETTLE_CYC  = 2,
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       CI,
    output logic [2:0] add_a,
    output logic [2:0] add_b,
    output logic       add_ci,
    input  logic [2:0] add_s,
    input  logic       add_co,
    output logic       busy,
    output logic       done,
    output logic [2:0] S,
    output logic       CO,
    output logic [1:0] an,
    output logic [6:0] SSeg
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [15:0] SCAN_LAST   = 16'(REFRESH_DIV - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  add_a_q, add_a_d, add_b_q, add_b_d, s_q, s_d;
    logic        add_ci_q, add_ci_d, co_q, co_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [15:0] scan_q, scan_d;
    logic        sel_q, sel_d;
    logic [1:0]  an_q, an_d;
    logic [6:0]  sseg_q, sseg_d;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        case (v)
            3'd0:    seg7 = 7'h3F;
            3'd1:    seg7 = 7'h06;
            3'd2:    seg7 = 7'h5B;
            3'd3:    seg7 = 7'h4F;
            3'd4:    seg7 = 7'h66;
            3'd5:    seg7 = 7'h6D;
            3'd6:    seg7 = 7'h7D;
            default: seg7 = 7'h07;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_ci_d = add_ci_q;
        s_d      = s_q;
        co_d     = co_q;
        case (state_q)
            IDLE: if (start) begin
                add_a_d  = A;
                add_b_d  = B;
                add_ci_d = CI;
                cnt_d    = 4'd0;
                state_d  = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    s_d     = add_s;
                    co_d    = add_co;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == SETTLE;
        done_d = state_d == DONE;
        scan_d = (scan_q == SCAN_LAST) ? 16'd0 : scan_q + 16'd1;
        sel_d  = sel_q ^ (scan_q == SCAN_LAST);
        // display registers use next-state values so they track S/CO from the capture edge
        an_d   = sel_d ? 2'b01 : 2'b10;
        sseg_d = seg7(sel_d ? {2'b00, co_d} : s_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_ci_q <= 1'b0;
            s_q      <= '0;
            co_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            scan_q   <= '0;
            sel_q    <= 1'b0;
            an_q     <= 2'b10;
            sseg_q   <= 7'h3F;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_ci_q <= add_ci_d;
            s_q      <= s_d;
            co_q     <= co_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            scan_q   <= scan_d;
            sel_q    <= sel_d;
            an_q     <= an_d;
            sseg_q   <= sseg_d;
        end
    end

    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign add_ci = add_ci_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign S      = s_q;
    assign CO     = co_q;
    assign an     = an_q;
    assign SSeg   = sseg_q;
endmodule

// File: doc/sum_seq_ctrl.md
SUM_SEQ_CTRL -- requirements
Module: sum_seq_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles allowed for the external adder to settle before capture; legal range 1..15.
REQ-002 Parameter REFRESH_DIV, default 4: clock cycles per display digit before the scan advances; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to latch A, B, CI and run one addition.
REQ-006 A  input  3  operand A, unsigned.
REQ-007 B  input  3  operand B, unsigned.
REQ-008 CI  input  1  carry-in.
REQ-009 add_a  output  3  registered operand A driven to the shared adder.
REQ-010 add_b  output  3  registered operand B driven to the shared adder.
REQ-011 add_ci  output  1  registered carry-in driven to the shared adder.
REQ-012 add_s  input  3  sum returned by the shared adder.
REQ-013 add_co  input  1  carry-out returned by the shared adder.
REQ-014 busy  output  1  high while an addition is in flight (state SETTLE).
REQ-015 done  output  1  one-cycle pulse; the result registers hold the new sum.
REQ-016 S  output  3  captured sum.
REQ-017 CO  output  1  captured carry-out.
REQ-018 an  output  2  digit enables, active-low; an[0] = digit 0 (S), an[1] = digit 1 (CO).
REQ-019 SSeg  output  7  segments {g,f,e,d,c,b,a}, active-high, for the enabled digit.

Function
REQ-020 The FSM SHALL have states IDLE, SETTLE and DONE, and no others reachable.
REQ-021 In IDLE, start=1 at a clock edge SHALL latch A/B/CI into add_a/add_b/add_ci, clear the settle counter, and enter SETTLE.
REQ-022 In SETTLE, each edge SHALL increment the settle counter; at the edge where the counter equals SETTLE_CYC-1, S<=add_s, CO<=add_co, and the FSM enters DONE.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-024 done SHALL be 1 only in DONE; busy SHALL be 1 only in SETTLE.
REQ-025 Latency: start accepted at edge k gives done=1 during cycle k+SETTLE_CYC to k+SETTLE_CYC+1.
REQ-026 start SHALL be ignored in SETTLE and DONE; A/B/CI changes during SETTLE SHALL NOT affect add_a/add_b/add_ci.
REQ-027 With start held at 1, accepts SHALL repeat every SETTLE_CYC+2 cycles.
REQ-028 add_a/add_b/add_ci SHALL hold their values after capture until the next accept.
REQ-029 The scan counter SHALL count 0..REFRESH_DIV-1 continuously, independent of the FSM; on wrap, digit select SHALL toggle.
REQ-030 Digit select 0 SHALL give an=2'b10 and the pattern of S; digit select 1 SHALL give an=2'b01 and the pattern of {2'b00,CO}.
REQ-031 Patterns 0..7 SHALL be 3F, 06, 5B, 4F, 66, 6D, 7D, 07 (hex).
REQ-032 an and SSeg SHALL be decoded only from registered state, so they are glitch-free, and SHALL reflect new S/CO from the capture edge onward.
REQ-033 {CO,S} SHALL equal A+B+CI (range 0..15) when paired with a correct 3-bit adder.

Reset
REQ-034 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, add_a=0, add_b=0, add_ci=0, S=0, CO=0, settle counter=0, scan counter=0, and digit select=0. Hence an=2'b10 and SSeg=7'h3F.
REQ-035 If reset asserts mid-SETTLE, the addition SHALL be aborted with no done pulse, S/CO SHALL be cleared, and operation SHALL restart in IDLE on the first edge after release.

Verification
REQ-036 Bench model: add_s/add_co = add_a + add_b + add_ci (combinational), SETTLE_CYC=2, REFRESH_DIV=4.
REQ-037 Case 1: A=3, B=2, CI=0, 1-cycle start pulse -> busy for 2 cycles, done after 2 edges, S=5, CO=0; digit 0 shows 6D and digit 1 shows 3F.
REQ-038 Case 2: A=7, B=7, CI=1 -> S=7, CO=1; an=10 with SSeg=07, and an=01 with SSeg=06, alternating every 4 cycles.
REQ-039 Case 3: start pulse, then A=1 and B=1 with start=1 during SETTLE -> result equals the first operands; no second accept until IDLE.
REQ-040 Case 4: start held high for 12 cycles -> exactly 3 done pulses, 4 cycles apart.
REQ-041 Case 5: rst_n=0 one cycle into SETTLE -> no done pulse; S=0, CO=0, an=10, SSeg=3F; the next start works normally.
REQ-042 Case 6: sweep all 128 A/B/CI combinations -> {CO,S}=A+B+CI each time, and the done count equals 128.
